kb_game_keymap: RTL and testbench
=================================

Name: kb_game_keymap

Overview:
- Parametrised successor to the fixed five-key game-key decoder.
- Consumes raw PS/2 scan-code bytes from the PS/2 receiver (valid strobe plus byte).
- Parses the E0 (extended) and F0 (break) prefixes itself, so it no longer relies on an upstream make/break flag.
- Maps N_KEYS programmable codes to per-key held levels plus one-cycle press/release pulses for game and menu logic.

Parameters:
- N_KEYS, 5: number of mapped keys; output width.
- KEY_TABLE, {9'h05A,9'h012,9'h042,9'h01B,9'h01D}: packed N_KEYS×9 bits. Entry i = bits [9i+8:9i]; bit 8 = extended (E0) flag, bits 7:0 = code. Default order from index 0 is W, S, K, Shift, Enter.
- TIMEOUT_CYC, 2_000_000: idle cycles after which a pending prefix is discarded (20 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: cycles before the first auto-repeat (optional feature only).
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeats (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rx_valid  in  1  one-cycle strobe: rx_data holds a new scan-code byte.
- rx_data  in  8  scan-code byte.
- key_held  out  N_KEYS  level; bit i = key i currently held.
- key_press  out  N_KEYS  one-cycle pulse on press (and on auto-repeat if enabled).
- key_release  out  N_KEYS  one-cycle pulse on release.
- prefix_busy  out  1  parser is mid-sequence (state ≠ IDLE).

Behaviour:
- Reset (reset=0, any time, async): key_held=0, key_press=0, key_release=0, prefix_busy=0, FSM=IDLE, all counters=0. A sequence interrupted by reset is discarded.
- All outputs are registered. A byte accepted at edge t is reflected in the outputs after edge t+1 (latency 1). Pulses are exactly one cycle wide.
- FSM states and transitions (bytes act only when rx_valid=1):
  - IDLE: E0→EXT; F0→BRK; other byte→make lookup {0,byte}, stay IDLE.
  - EXT: F0→EXT_BRK; E0→EXT (repeated prefix tolerated); other byte→make lookup {1,byte}, →IDLE.
  - BRK: any byte→break lookup {0,byte}, →IDLE (E0/F0 are looked up as plain codes; they never match valid entries).
  - EXT_BRK: any byte→break lookup {1,byte}, →IDLE.
- Make lookup, for every entry i whose 9-bit value matches (duplicates all update):
  - key_held[i]←1.
  - key_press[i] pulses only if key_held[i] was 0; keyboard typematic repeats produce no pulse.
- Break lookup, for every matching entry i:
  - key_held[i]←0.
  - key_release[i] pulses only if key_held[i] was 1.
- Unmatched codes (including AA, FA, FE in IDLE) are ignored; state still advances as above.
- Timeout: in any non-IDLE state, a cycle counter increments on every cycle without rx_valid. At TIMEOUT_CYC−1 the FSM returns to IDLE and the counter clears; no key changes. The counter also clears on every rx_valid.
- A byte arriving in the same cycle the timeout fires is processed as if in the pre-timeout state (the byte has priority).
- Counter width is $clog2(max(TIMEOUT_CYC, REPEAT_DELAY, REPEAT_PERIOD)+1). Counters saturate and never wrap.

Optional Feature:
- KB_AUTOREPEAT_EN defined:
  - A single repeat engine tracks the most recently pressed key index (last new press wins).
  - After REPEAT_DELAY cycles held, key_press[idx] pulses, then again every REPEAT_PERIOD cycles.
  - The engine stops and clears when that key is released, or when another key is newly pressed (it then restarts timing for the new key).
  - Keyboard typematic makes do not reset the timing.
- KB_AUTOREPEAT_EN undefined:
  - key_press fires only on 0→1 of key_held.
  - The repeat logic and REPEAT_* counters are absent; the REPEAT_* parameters are unused.

Decomposition:
- Package kb_pkg holds:
  - scan-code constants (KB_PFX_EXT=8'hE0, KB_PFX_BRK=8'hF0, W/S/K/Shift/Enter/arrow codes);
  - the parser state enum (IDLE, EXT, BRK, EXT_BRK);
  - key-index constants for the default table.
- One sub-module is natural: kb_prefix_parser (FSM + timeout). It outputs a one-cycle event {valid, is_break, ext, code}.
- The top level does table match, held/pulse generation and auto-repeat.

Test Plan:
- Reset then send 1D → key_held=5'b00001 and key_press[0] pulses at t+1; then send 1D again → no second pulse.
- Send F0,1D → key_held[0]=0 and key_release[0] pulses once; a further F0,1D → no pulse.
- KEY_TABLE entry 5 = 9'h175 (extended Up): E0,75 → key_held[5]=1; plain 75 → no change; E0,F0,75 → release[5].
- Send F0 then no byte for TIMEOUT_CYC (set to 100) cycles → prefix_busy drops at cycle 100; a following 1D is treated as a make (held[0]=1).
- Hold 12 (Shift) and 5A (Enter) simultaneously, release 12 only → key_held=5'b10000; assert reset=0 mid-sequence after E0 → all outputs 0, FSM IDLE.
- With KB_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5: press 1B and hold → press pulses at t+1, t+21, t+26, t+31; press 42 → repeats move to index 2.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared scan-code constants, parser state encoding and parsed-event type for the game keymap.
// Latency: n/a (declarations only).
// Backpressure: n/a; the keymap has no backpressure and accepts every valid byte.
package kb_pkg;

    // PS/2 set-2 prefixes
    localparam logic [7:0] KB_PFX_EXT   = 8'hE0;
    localparam logic [7:0] KB_PFX_BRK   = 8'hF0;

    // Plain codes used by the default table
    localparam logic [7:0] KB_CODE_W     = 8'h1D;
    localparam logic [7:0] KB_CODE_S     = 8'h1B;
    localparam logic [7:0] KB_CODE_K     = 8'h42;
    localparam logic [7:0] KB_CODE_SHIFT = 8'h12;
    localparam logic [7:0] KB_CODE_ENTER = 8'h5A;

    // Arrow keys (these only arrive behind an E0 prefix)
    localparam logic [7:0] KB_CODE_UP    = 8'h75;
    localparam logic [7:0] KB_CODE_DOWN  = 8'h72;
    localparam logic [7:0] KB_CODE_LEFT  = 8'h6B;
    localparam logic [7:0] KB_CODE_RIGHT = 8'h74;

    // Key indices for the default KEY_TABLE
    localparam int KB_IDX_W     = 0;
    localparam int KB_IDX_S     = 1;
    localparam int KB_IDX_K     = 2;
    localparam int KB_IDX_SHIFT = 3;
    localparam int KB_IDX_ENTER = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_e;

    // One fully parsed key event
    typedef struct packed {
        logic       is_break;
        logic       ext;
        logic [7:0] code;
    } kb_event_t;

    function automatic int kb_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/kb_prefix_parser.sv
// PS/2 prefix parser: folds E0/F0 prefixes into a single {is_break, ext, code} event; drops stale prefixes.
// Latency: event registered on the edge that accepts the final byte of a sequence (1 cycle).
// Backpressure: none; every rx_valid byte is consumed.
//
// Ports: clk, reset (async, active low), rx_valid/rx_data (raw scan bytes),
//        ev_valid/ev (one-cycle parsed event), busy (state is not IDLE).
module kb_prefix_parser
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int CNT_W       = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    output kb_event_t  ev,
    output logic       busy
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    kb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev_valid_d;
    kb_event_t        ev_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ev_valid <= 1'b0;
            ev       <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ev_valid <= ev_valid_d;
            ev       <= ev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ev_valid_d = 1'b0;
        ev_d       = '0;

        // A byte always wins over the timeout in the same cycle.
        if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == KB_PFX_EXT)      state_d = ST_EXT;
                    else if (rx_data == KB_PFX_BRK) state_d = ST_BRK;
                    else begin
                        ev_valid_d = 1'b1;
                        ev_d       = '{is_break: 1'b0, ext: 1'b0, code: rx_data};
                    end
                end
                ST_EXT: begin
                    if (rx_data == KB_PFX_BRK)      state_d = ST_EXT_BRK;
                    else if (rx_data == KB_PFX_EXT) state_d = ST_EXT;
                    else begin
                        ev_valid_d = 1'b1;
                        ev_d       = '{is_break: 1'b0, ext: 1'b1, code: rx_data};
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    // Prefix bytes here are looked up as plain codes and simply never match.
                    ev_valid_d = 1'b1;
                    ev_d       = '{is_break: 1'b1, ext: 1'b0, code: rx_data};
                    state_d    = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    ev_valid_d = 1'b1;
                    ev_d       = '{is_break: 1'b1, ext: 1'b1, code: rx_data};
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == TO_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/kb_game_keymap.sv
// Game keymap: maps N_KEYS programmable (ext, code) entries to held levels and press/release pulses.
// Latency: byte accepted at edge t shows on outputs after edge t+1; pulses are one cycle wide.
// Backpressure: none; every rx_valid byte is consumed.
//
// Ports: clk, reset (async, active low), rx_valid/rx_data (raw scan bytes),
//        key_held (levels), key_press / key_release (one-cycle pulses), prefix_busy.
// Optional macro KB_AUTOREPEAT_EN adds a single auto-repeat engine on the last newly pressed key.
module kb_game_keymap
    import kb_pkg::*;
#(
    parameter int                  N_KEYS        = 5,
    parameter logic [N_KEYS*9-1:0] KEY_TABLE     = {9'h05A, 9'h012, 9'h042, 9'h01B, 9'h01D},
    parameter int                  TIMEOUT_CYC   = 2_000_000,
    parameter int                  REPEAT_DELAY  = 50_000_000,
    parameter int                  REPEAT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [N_KEYS-1:0] key_held,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              prefix_busy
);

    // One width for every cycle counter so timeout and repeat counts share a range.
    localparam int CNT_W = $clog2(kb_max3(TIMEOUT_CYC, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic        ev_valid;
    kb_event_t   ev;
    logic        parser_busy;

    kb_prefix_parser #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_parser (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .ev_valid (ev_valid),
        .ev       (ev),
        .busy     (parser_busy)
    );

    logic [N_KEYS-1:0] hit;
    logic [N_KEYS-1:0] held_d;
    logic [N_KEYS-1:0] new_press;
    logic [N_KEYS-1:0] release_d;
    logic [N_KEYS-1:0] rpt_vec;

    // Every matching entry responds, so duplicate table entries track together.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            hit[i] = (KEY_TABLE[9*i +: 9] == {ev.ext, ev.code});
        end
    end

    always_comb begin
        held_d    = key_held;
        new_press = '0;
        release_d = '0;
        if (ev_valid) begin
            if (ev.is_break) begin
                held_d    = key_held & ~hit;
                release_d = key_held & hit;
            end else begin
                held_d    = key_held | hit;
                new_press = ~key_held & hit;   // typematic makes of a held key stay silent
            end
        end
    end

`ifdef KB_AUTOREPEAT_EN
    localparam int               IDX_W    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             rpt_act_q,  rpt_act_d;
    logic             rpt_per_q,  rpt_per_d;   // 0: waiting out the initial delay, 1: periodic
    logic [IDX_W-1:0] rpt_idx_q,  rpt_idx_d;
    logic [CNT_W-1:0] rpt_cnt_q,  rpt_cnt_d;
    logic             rpt_fire;
    logic             np_any;
    logic [IDX_W-1:0] np_idx;

    // Highest index wins if one event newly presses several duplicate entries.
    always_comb begin
        np_any = 1'b0;
        np_idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (new_press[i]) begin
                np_any = 1'b1;
                np_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        rpt_act_d = rpt_act_q;
        rpt_per_d = rpt_per_q;
        rpt_idx_d = rpt_idx_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (np_any) begin
            // A fresh press retargets the engine and restarts the delay.
            rpt_act_d = 1'b1;
            rpt_per_d = 1'b0;
            rpt_idx_d = np_idx;
            rpt_cnt_d = '0;
        end else if (rpt_act_q) begin
            if (release_d[rpt_idx_q]) begin
                rpt_act_d = 1'b0;
                rpt_per_d = 1'b0;
                rpt_cnt_d = '0;
            end else if (rpt_cnt_q == (rpt_per_q ? PER_LAST : DLY_LAST)) begin
                rpt_fire  = 1'b1;
                rpt_per_d = 1'b1;
                rpt_cnt_d = '0;
            end else if (rpt_cnt_q != '1) begin
                rpt_cnt_d = rpt_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        rpt_vec = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            rpt_vec[i] = rpt_fire && (rpt_idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_act_q <= 1'b0;
            rpt_per_q <= 1'b0;
            rpt_idx_q <= '0;
            rpt_cnt_q <= '0;
        end else begin
            rpt_act_q <= rpt_act_d;
            rpt_per_q <= rpt_per_d;
            rpt_idx_q <= rpt_idx_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign rpt_vec = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            prefix_busy <= 1'b0;
        end else begin
            key_held    <= held_d;
            key_press   <= new_press | rpt_vec;
            key_release <= release_d;
            prefix_busy <= parser_busy;
        end
    end

endmodule

// File: tb/tb_kb_game_keymap.sv
// Scoreboard bench for kb_game_keymap: stimulus queues expected pulses and levels, a monitor compares them.
// Latency under check: byte driven at negedge cycle c appears at negedge cycle c+2.
// Backpressure: none.
module tb_kb_game_keymap;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [5:0] key_held;
    logic [5:0] key_press;
    logic [5:0] key_release;
    logic       prefix_busy;

    kb_game_keymap #(
        .N_KEYS        (6),
        .KEY_TABLE     ({9'h175, 9'h05A, 9'h012, 9'h042, 9'h01B, 9'h01D}),
        .TIMEOUT_CYC   (100),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .prefix_busy (prefix_busy)
    );

    typedef struct {
        int         cyc;
        logic [5:0] press;
        logic [5:0] rel;
        logic [5:0] held;
    } pls_t;

    typedef struct {
        int         cyc;
        int         id;
        logic [5:0] held;
        logic       busy;
    } lvl_t;

    pls_t pls_q[$];
    lvl_t lvl_q[$];
    pls_t p;
    lvl_t e;

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;
    int t_out   = 0;
    int base    = 0;
    int b2      = 0;
    logic done  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t_out    = cyc + 2;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic exp_pulse(input int c, input logic [5:0] pr, input logic [5:0] rl, input logic [5:0] h);
        pls_q.push_back('{cyc: c, press: pr, rel: rl, held: h});
    endtask

    task automatic exp_lvl(input int c, input int id, input logic [5:0] h, input logic b);
        lvl_q.push_back('{cyc: c, id: id, held: h, busy: b});
    endtask

    // Monitor: the only place comparisons happen.
    always @(negedge clk) begin
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            e = lvl_q.pop_front();
            n_check++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL level%0d not sampled: now cycle %0d, required cycle %0d", e.id, cyc, e.cyc);
            end else if (key_held !== e.held || prefix_busy !== e.busy) begin
                n_fail++;
                $display("FAIL level%0d @%0d: held=%b busy=%b, required held=%b busy=%b",
                         e.id, cyc, key_held, prefix_busy, e.held, e.busy);
            end
        end
        while (pls_q.size() > 0 && pls_q[0].cyc < cyc) begin
            p = pls_q.pop_front();
            n_check++;
            n_fail++;
            $display("FAIL pulse missing at cycle %0d, required press=%b release=%b",
                     p.cyc, p.press, p.rel);
        end
        if ((key_press | key_release) !== 6'b0) begin
            n_check++;
            if (pls_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse unexpected @%0d: press=%b release=%b, required none",
                         cyc, key_press, key_release);
            end else begin
                p = pls_q.pop_front();
                if (p.cyc != cyc || key_press !== p.press || key_release !== p.rel || key_held !== p.held) begin
                    n_fail++;
                    $display("FAIL pulse @%0d: press=%b release=%b held=%b, required @%0d press=%b release=%b held=%b",
                             cyc, key_press, key_release, key_held, p.cyc, p.press, p.rel, p.held);
                end
            end
        end
        if (done) begin
            n_check++;
            if (pls_q.size() != 0) begin
                n_fail++;
                $display("FAIL pulse queue at end: %0d left, required 0", pls_q.size());
            end
            n_check++;
            if (lvl_q.size() != 0) begin
                n_fail++;
                $display("FAIL level queue at end: %0d left, required 0", lvl_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
            $finish;
        end
        if (cyc > 4000) begin
            n_fail++;
            $display("FAIL watchdog: cycle %0d, required finish before 4000", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        exp_lvl(cyc + 1, 1, 6'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;

`ifdef KB_AUTOREPEAT_EN
        // S (1B) held: press at base, repeats after 20 then every 5.
        send(8'h1B);
        base = t_out;
        exp_pulse(base,      6'h02, 6'h00, 6'h02);
        exp_pulse(base + 20, 6'h02, 6'h00, 6'h02);
        exp_pulse(base + 25, 6'h02, 6'h00, 6'h02);
        exp_pulse(base + 30, 6'h02, 6'h00, 6'h02);
        repeat (31) @(negedge clk);
        // K (42) newly pressed: engine moves to index 2 and restarts its delay.
        send(8'h42);
        b2 = t_out;
        exp_pulse(b2,      6'h04, 6'h00, 6'h06);
        exp_pulse(b2 + 20, 6'h04, 6'h00, 6'h06);
        exp_pulse(b2 + 25, 6'h04, 6'h00, 6'h06);
        exp_pulse(b2 + 30, 6'h04, 6'h00, 6'h06);
        repeat (27) @(negedge clk);
        send(8'hF0);
        send(8'h42);
        exp_pulse(t_out, 6'h00, 6'h04, 6'h02);
        exp_lvl(t_out, 20, 6'h02, 1'b0);
        repeat (40) @(negedge clk);
`else
        // Make W, then typematic repeat of W.
        send(8'h1D);  exp_pulse(t_out, 6'h01, 6'h00, 6'h01);
        send(8'h1D);  exp_lvl(t_out, 2, 6'h01, 1'b0);
        // Break W; a second break is silent.
        send(8'hF0);  exp_lvl(t_out, 3, 6'h01, 1'b1);
        send(8'h1D);  exp_pulse(t_out, 6'h00, 6'h01, 6'h00); exp_lvl(t_out, 4, 6'h00, 1'b0);
        send(8'hF0);
        send(8'h1D);  exp_lvl(t_out, 5, 6'h00, 1'b0);
        // Extended Up on entry 5; plain 75 must not match it.
        send(8'hE0);  exp_lvl(t_out, 6, 6'h00, 1'b1);
        send(8'h75);  exp_pulse(t_out, 6'h20, 6'h00, 6'h20);
        send(8'h75);  exp_lvl(t_out, 7, 6'h20, 1'b0);
        send(8'hE0);
        send(8'hF0);  exp_lvl(t_out, 8, 6'h20, 1'b1);
        send(8'h75);  exp_pulse(t_out, 6'h00, 6'h20, 6'h00); exp_lvl(t_out, 9, 6'h00, 1'b0);
        // Stale F0 expires after 100 idle cycles; following 1D is a make.
        send(8'hF0);
        exp_lvl(t_out + 99,  10, 6'h00, 1'b1);
        exp_lvl(t_out + 100, 11, 6'h00, 1'b0);
        repeat (105) @(negedge clk);
        send(8'h1D);  exp_pulse(t_out, 6'h01, 6'h00, 6'h01); exp_lvl(t_out, 12, 6'h01, 1'b0);
        // Shift + Enter together, release W and Shift.
        send(8'h12);  exp_pulse(t_out, 6'h08, 6'h00, 6'h09);
        send(8'h5A);  exp_pulse(t_out, 6'h10, 6'h00, 6'h19);
        send(8'hF0);
        send(8'h1D);  exp_pulse(t_out, 6'h00, 6'h01, 6'h18);
        send(8'hF0);
        send(8'h12);  exp_pulse(t_out, 6'h00, 6'h08, 6'h10); exp_lvl(t_out, 13, 6'h10, 1'b0);
        // Reset in the middle of an E0 sequence.
        send(8'hE0);  exp_lvl(t_out, 14, 6'h10, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_lvl(cyc, 15, 6'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        // Parser must be back in IDLE: 1D is a plain make.
        send(8'h1D);  exp_pulse(t_out, 6'h01, 6'h00, 6'h01); exp_lvl(t_out, 16, 6'h01, 1'b0);
        repeat (10) @(negedge clk);
`endif
        done = 1'b1;
    end

endmodule
